seven_seg_scanner: RTL and testbench

- Downstream of display_data_generator: consumes its 8×6-bit character codes and decimal-point bits and drives a time-multiplexed 8-digit common-select 7-segment display.
- Snapshots the frame once per scan cycle so there is no tearing, inserts a blanking interval before each digit to suppress ghosting, and decodes character codes to segment patterns.

---
 rtl/seven_seg_scanner_pkg.sv | 18 +
 rtl/seven_seg_scanner_seg_decoder.sv | 41 ++++
 rtl/seven_seg_scanner.sv | 149 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: character codes and scan phase.
package seven_seg_scanner_pkg;

  localparam logic [5:0] CH_BLANK = 6'h3F;
  localparam logic [5:0] CH_A     = 6'd10;
  localparam logic [5:0] CH_E     = 6'd14;
  localparam logic [5:0] CH_J     = 6'd19;
  localparam logic [5:0] CH_N     = 6'd23;
  localparam logic [5:0] CH_O     = 6'd24;
  localparam logic [5:0] CH_P     = 6'd25;
  localparam logic [5:0] CH_R     = 6'd27;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_phase_t;

endpackage

// File: rtl/seven_seg_scanner_seg_decoder.sv
// Combinational character-code to {g,f,e,d,c,b,a} decoder; unlisted codes are dark.
module seg_decoder
  import seven_seg_scanner_pkg::*;
(
  input  logic [5:0] code,
  output logic [6:0] segs
);

  // Character table lookup
  always_comb begin
    segs = 7'h00;
    case (code)
      6'd0:    segs = 7'h3F;
      6'd1:    segs = 7'h06;
      6'd2:    segs = 7'h5B;
      6'd3:    segs = 7'h4F;
      6'd4:    segs = 7'h66;
      6'd5:    segs = 7'h6D;
      6'd6:    segs = 7'h7D;
      6'd7:    segs = 7'h07;
      6'd8:    segs = 7'h7F;
      6'd9:    segs = 7'h6F;
      CH_A:    segs = 7'h77;
      6'd11:   segs = 7'h7C;
      6'd12:   segs = 7'h39;
      6'd13:   segs = 7'h5E;
      CH_E:    segs = 7'h79;
      6'd15:   segs = 7'h71;
      6'd17:   segs = 7'h76;
      CH_J:    segs = 7'h1E;
      6'd21:   segs = 7'h38;
      CH_N:    segs = 7'h37;
      CH_O:    segs = 7'h3F;
      CH_P:    segs = 7'h73;
      CH_R:    segs = 7'h50;
      6'd30:   segs = 7'h3E;
      default: segs = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit 7-segment driver with per-frame snapshot and per-slot blanking.
// All pins are registered: the pattern for (cnt, idx) appears one clock later.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int SCAN_DIVIDE    = 10000,
  parameter int BLANK_CYCLES   = 100,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [7:0][5:0] display_code,
  input  logic [7:0]      display_dp,
  output logic [7:0]      digit_sel,
  output logic [6:0]      segment,
  output logic            seg_dp,
  output logic            frame_start
);

  localparam int              CNT_W     = $clog2(SCAN_DIVIDE);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIVIDE - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [7:0]      DIG_MASK  = DIG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0]      SEG_MASK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [2:0]       idx_r, idx_next_s;
  logic             wrap_s;
  scan_phase_t      phase_r, phase_next_s;

  logic [7:0][5:0]  code_snap_r;
  logic [7:0]       dp_snap_r;
  logic             frame_hit_s;

  logic [6:0]       seg_dec_s;
  logic [7:0]       dig_lgc_s;
  logic [6:0]       seg_lgc_s;
  logic             dp_lgc_s;

  logic [7:0]       digit_sel_r;
  logic [6:0]       segment_r;
  logic             seg_dp_r;
  logic             frame_start_r;

  // Slot counter and digit index advance
  always_comb begin
    wrap_s     = (cnt_r == CNT_MAX);
    cnt_next_s = cnt_r;
    idx_next_s = idx_r;
    if (wrap_s) begin
      cnt_next_s = CNT_ZERO;
      idx_next_s = idx_r + 3'd1;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
      idx_next_s = idx_r;
    end
  end

  // Phase next-state: leave BLANK when the counter reaches BLANK_CYCLES, return at slot wrap
  always_comb begin
    phase_next_s = phase_r;
    case (phase_r)
      BLANK: begin
        if (cnt_next_s == BLANK_END) phase_next_s = DRIVE;
        else                         phase_next_s = BLANK;
      end
      DRIVE: begin
        if (wrap_s) phase_next_s = BLANK;
        else        phase_next_s = DRIVE;
      end
      default: phase_next_s = BLANK;
    endcase
  end

  // Counter and phase state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      phase_r <= BLANK;
    end else begin
      cnt_r   <= cnt_next_s;
      idx_r   <= idx_next_s;
      phase_r <= phase_next_s;
    end
  end

  assign frame_hit_s = (cnt_r == CNT_ZERO) && (idx_r == 3'd0);

  // Whole-frame snapshot taken once per scan so a frame never mixes old and new data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      code_snap_r <= {8{CH_BLANK}};
      dp_snap_r   <= 8'h00;
    end else if (frame_hit_s) begin
      code_snap_r <= display_code;
      dp_snap_r   <= display_dp;
    end else begin
      code_snap_r <= code_snap_r;
      dp_snap_r   <= dp_snap_r;
    end
  end

  seg_decoder u_seg_decoder (
    .code (code_snap_r[idx_r]),
    .segs (seg_dec_s)
  );

  // Logical (active-high) pin pattern for the current slot position
  always_comb begin
    dig_lgc_s = 8'h00;
    seg_lgc_s = 7'h00;
    dp_lgc_s  = 1'b0;
    if (enable && (phase_r == DRIVE)) begin
      dig_lgc_s = 8'h01 << idx_r;
      seg_lgc_s = seg_dec_s;
      dp_lgc_s  = dp_snap_r[idx_r];
    end else begin
      dig_lgc_s = 8'h00;
      seg_lgc_s = 7'h00;
      dp_lgc_s  = 1'b0;
    end
  end

  // Output flops with pin polarity applied
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      digit_sel_r   <= DIG_MASK;
      segment_r     <= SEG_MASK;
      seg_dp_r      <= SEG_ACTIVE_LOW;
      frame_start_r <= 1'b0;
    end else begin
      digit_sel_r   <= dig_lgc_s ^ DIG_MASK;
      segment_r     <= seg_lgc_s ^ SEG_MASK;
      seg_dp_r      <= dp_lgc_s ^ SEG_ACTIVE_LOW;
      frame_start_r <= frame_hit_s;
    end
  end

  assign digit_sel   = digit_sel_r;
  assign segment     = segment_r;
  assign seg_dp      = seg_dp_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench: a cycle-level reference computed from elapsed clocks since reset release.
module tb_seven_seg_scanner;
  import seven_seg_scanner_pkg::*;

  localparam int SD = 8;
  localparam int BC = 2;

  logic            clock;
  logic            reset_n;
  logic            enable;
  logic [7:0][5:0] display_code;
  logic [7:0]      display_dp;
  logic [7:0]      digit_sel;
  logic [6:0]      segment;
  logic            seg_dp;
  logic            frame_start;

  int checks;
  int failures;

  // Reference state: clocks since release plus the model's own frame snapshot
  int         t;
  logic [5:0] m_code [8];
  logic [7:0] m_dp;
  logic [6:0] lut [64];

  seven_seg_scanner #(
    .SCAN_DIVIDE    (SD),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .display_code (display_code),
    .display_dp   (display_dp),
    .digit_sel    (digit_sel),
    .segment      (segment),
    .seg_dp       (seg_dp),
    .frame_start  (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_off(input string tag);
    checks++;
    assert (digit_sel === 8'hFF) else begin
      failures++; $error("FAIL %s digit_sel got=%h exp=ff", tag, digit_sel);
    end
    checks++;
    assert (segment === 7'h7F) else begin
      failures++; $error("FAIL %s segment got=%h exp=7f", tag, segment);
    end
    checks++;
    assert (seg_dp === 1'b1) else begin
      failures++; $error("FAIL %s seg_dp got=%b exp=1", tag, seg_dp);
    end
    checks++;
    assert (frame_start === 1'b0) else begin
      failures++; $error("FAIL %s frame_start got=%b exp=0", tag, frame_start);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_code[i] = 6'h3F;
    m_dp = 8'h00;
    t = 0;
  endtask

  // One clock: predict pins from the pre-edge position, then compare after the edge
  task automatic tick();
    int         cnt;
    logic [2:0] idx;
    logic [7:0] e_dig;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;
    cnt = t % SD;
    idx = 3'((t / SD) % 8);
    if (enable && cnt >= BC) begin
      e_dig = ~(8'h01 << idx);
      e_seg = ~lut[m_code[idx]];
      e_dp  = ~m_dp[idx];
    end else begin
      e_dig = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end
    e_fs = (t % (SD * 8)) == 0;
    if (e_fs) begin
      for (int i = 0; i < 8; i++) m_code[i] = display_code[i];
      m_dp = display_dp;
    end
    @(posedge clock);
    #1;
    checks++;
    assert (digit_sel === e_dig) else begin
      failures++; $error("FAIL digit_sel t=%0d got=%h exp=%h", t, digit_sel, e_dig);
    end
    checks++;
    assert (segment === e_seg) else begin
      failures++; $error("FAIL segment t=%0d got=%h exp=%h", t, segment, e_seg);
    end
    checks++;
    assert (seg_dp === e_dp) else begin
      failures++; $error("FAIL seg_dp t=%0d got=%b exp=%b", t, seg_dp, e_dp);
    end
    checks++;
    assert (frame_start === e_fs) else begin
      failures++; $error("FAIL frame_start t=%0d got=%b exp=%b", t, frame_start, e_fs);
    end
    checks++;
    assert ($countones(~digit_sel) <= 1) else begin
      failures++; $error("FAIL onehot t=%0d got=%h exp=at_most_one_low", t, digit_sel);
    end
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) lut[i] = 7'h00;
    lut[0]  = 7'h3F; lut[1]  = 7'h06; lut[2]  = 7'h5B; lut[3]  = 7'h4F;
    lut[4]  = 7'h66; lut[5]  = 7'h6D; lut[6]  = 7'h7D; lut[7]  = 7'h07;
    lut[8]  = 7'h7F; lut[9]  = 7'h6F; lut[10] = 7'h77; lut[11] = 7'h7C;
    lut[12] = 7'h39; lut[13] = 7'h5E; lut[14] = 7'h79; lut[15] = 7'h71;
    lut[17] = 7'h76; lut[19] = 7'h1E; lut[21] = 7'h38; lut[23] = 7'h37;
    lut[24] = 7'h3F; lut[25] = 7'h73; lut[27] = 7'h50; lut[30] = 7'h3E;

    reset_n    = 1'b0;
    enable     = 1'b1;
    display_dp = 8'h00;
    for (int i = 0; i < 8; i++) display_code[i] = 6'(8 - i);
    clear_model();
    repeat (3) @(negedge clock);
    check_off("reset");

    // First frame: digits 7..0 show 1..8
    reset_n = 1'b1;
    run(64);

    // Letters and blank
    display_code = {CH_J, CH_A, CH_R, CH_BLANK, 6'd0, 6'd0, 6'd4, 6'd2};
    run(64);

    // Snapshot stability: change digit 0 mid slot 3
    display_code[0] = 6'd1;
    run(64);
    run(28);
    display_code[0] = 6'd9;
    run(36);
    run(64);

    // Decimal point and enable drop
    display_dp = 8'h01;
    run(64);
    run(20);
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(39);

    // Randomised inputs
    for (int i = 0; i < 320; i++) begin
      if ($urandom_range(0, 3) == 0)
        display_code[$urandom_range(0, 7)] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) display_dp = 8'($urandom_range(0, 255));
      enable = ($urandom_range(0, 7) != 0);
      tick();
    end

    // Asynchronous reset in slot 5, between clock edges
    enable = 1'b1;
    while ((t % 64) != 44) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_off("async_reset");
    @(negedge clock);
    @(negedge clock);
    check_off("reset_hold");
    display_code = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8};
    display_dp   = 8'h80;
    clear_model();
    reset_n = 1'b1;
    run(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
